pipelined_carry_skip_adder: RTL

Parametrised, pipelined successor to the team's 4-bit-block carry-skip adder. It adds or subtracts two N-bit operands using carry-skip blocks of configurable width. The carry chain is split across a configurable number of register stages. It sits on the datapath between operand-fetch and writeback, uses a valid/ready handshake on both sides, and reports carry-out and signed overflow per result.

---
 rtl/pipelined_carry_skip_adder_if.sv | 52 +++++
 rtl/pipelined_carry_skip_adder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_skip_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_carry_skip_adder_if
//
// Purpose : Bundles the operand-side and result-side valid/ready handshakes of
//           pipelined_carry_skip_adder into one interface. The producer and the
//           consumer of the adder both sit on the master side. The adder itself
//           connects to the slave side.
//
// Parameter:
//   N          operand/result width; must match the N of the adder instance.
//
// Signals:
//   in_valid   master -> slave   operand set present
//   in_ready   slave  -> master  adder accepts operands this cycle
//   A, B       master -> slave   N-bit operands
//   cin        master -> slave   carry-in (add) / borrow-in (subtract)
//   sub        master -> slave   0 = add, 1 = subtract
//   out_valid  slave  -> master  result present
//   out_ready  master -> slave   consumer accepts result this cycle
//   S          slave  -> master  N-bit sum/difference
//   cout       slave  -> master  carry-out of MSB (subtract: 1 = no borrow)
//   OF         slave  -> master  signed two's-complement overflow
// -----------------------------------------------------------------------------
interface pipelined_carry_skip_adder_if #(
    parameter int N = 32
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         cout;
    logic         OF;

    // Producer/consumer view.
    modport master (
        output in_valid, A, B, cin, sub, out_ready,
        input  in_ready, out_valid, S, cout, OF
    );

    // Adder view.
    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
        output in_ready, out_valid, S, cout, OF
    );

endinterface

// File: rtl/pipelined_carry_skip_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_skip_adder
//
// Purpose : Pipelined N-bit adder/subtractor built from BLK-bit carry-skip
//           blocks. The N/BLK blocks are split evenly over STAGES register
//           stages. Stage k resolves block group k and registers the low sum
//           bits produced so far, the group carry-out, and the operand bits
//           that later stages still need. The last stage register is the
//           output register.
//
//           Flow control uses one global enable, adv = !out_valid || out_ready.
//           Every stage shifts when adv is high and holds when it is low.
//           Bubbles travel as valid=0 and are never collapsed.
//
// Parameters:
//   N       operand/result width; N % BLK == 0
//   BLK     carry-skip block width, >= 2
//   STAGES  register stages, 1..N/BLK, with (N/BLK) % STAGES == 0
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous, active-high reset; clears every valid bit and every
//           data/carry register
//   bus     pipelined_carry_skip_adder_if.slave (handshakes, operands, results);
//           its N must equal this module's N
//
// Optional feature:
//   CSA_SAT_EN  when defined, S is clamped to the most positive or most
//               negative value whenever OF=1. cout and OF always describe the
//               unsaturated sum.
// -----------------------------------------------------------------------------
module pipelined_carry_skip_adder #(
    parameter int N      = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    pipelined_carry_skip_adder_if.slave   bus
);

    localparam int NBLK = N / BLK;        // carry-skip blocks in total
    localparam int GBLK = NBLK / STAGES;  // blocks resolved per stage
    localparam int W    = GBLK * BLK;     // bits resolved per stage

    if ((N % BLK) != 0 || BLK < 2 || STAGES < 1 || STAGES > NBLK ||
        (NBLK % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_carry_skip_adder: illegal N/BLK/STAGES combination");
    end

    // -------------------------------------------------------------------------
    // One group of GBLK carry-skip blocks.
    // Each block ripples its BLK bits. When every propagate bit in the block
    // is 1, the skip mux forwards the block's carry-in directly. The logical
    // result is unchanged, but the carry path through the group becomes GBLK
    // skip muxes instead of W ripple cells.
    // Returns {group carry-out, W sum bits}.
    // -------------------------------------------------------------------------
    function automatic logic [W:0] skip_group(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         c
    );
        logic [W-1:0]   s;
        logic [BLK-1:0] p;
        logic           carry;
        logic           blk_cin;
        // NOTE: variables inside a function are plain temporaries evaluated
        // in order, so blocking '=' is required here. Sequential state
        // elsewhere uses '<='.
        s     = '0;
        carry = c;
        for (int j = 0; j < GBLK; j++) begin
            blk_cin = carry;
            for (int i = 0; i < BLK; i++) begin
                p[i]           = a[j*BLK+i] ^ b[j*BLK+i];
                s[j*BLK+i]     = p[i] ^ carry;
                carry          = (a[j*BLK+i] & b[j*BLK+i]) | (p[i] & carry);
            end
            if (&p) begin
                carry = blk_cin;
            end
        end
        return {carry, s};
    endfunction

    // -------------------------------------------------------------------------
    // Global pipeline enable and effective operands
    // -------------------------------------------------------------------------
    logic         out_valid_q;
    logic [N-1:0] s_q;
    logic         cout_q;
    logic         of_q;

    logic         adv;
    logic [N-1:0] b_eff;
    logic         c_eff;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // Subtraction is A + ~B + (cin ^ 1). With cin=0 this gives A-B, and with
    // cin=1 (borrow-in) it gives A-B-1.
    assign b_eff = bus.B ^ {N{bus.sub}};
    assign c_eff = bus.cin ^ bus.sub;

    // -------------------------------------------------------------------------
    // Intermediate stages 0 .. STAGES-2
    //   x carries the sum bits below HI and operand A at and above HI.
    //   y carries operand Beff at and above HI only. Lower Beff bits are
    //   consumed and dropped.
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
        localparam int LO = k * W;
        localparam int HI = LO + W;

        logic          v_in;
        logic          c_in;
        logic [N-1:0]  x_in;
        logic [N-1:LO] y_in;

        logic [W:0]    grp;
        logic [N-1:0]  x_d;

        logic          v_q;
        logic          c_q;
        logic [N-1:0]  x_q;
        logic [N-1:HI] y_q;

        if (k == 0) begin : g_src
            assign v_in = bus.in_valid;
            assign c_in = c_eff;
            assign x_in = bus.A;
            assign y_in = b_eff;
        end else begin : g_src
            assign v_in = g_stage[k-1].v_q;
            assign c_in = g_stage[k-1].c_q;
            assign x_in = g_stage[k-1].x_q;
            assign y_in = g_stage[k-1].y_q;
        end

        assign grp = skip_group(x_in[HI-1:LO], y_in[HI-1:LO], c_in);

        // Overwrite this group's operand-A bits with its sum bits.
        always_comb begin
            // NOTE: assigning x_d in full before the partial overwrite means
            // every bit is written on every pass, so no latch is inferred.
            x_d          = x_in;
            x_d[HI-1:LO] = grp[W-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                x_q <= '0;
                y_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                // Data registers load only with a real operation, so bubbles
                // leave them untouched.
                if (v_in) begin
                    c_q <= grp[W];
                    x_q <= x_d;
                    y_q <= y_in[N-1:HI];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Final stage: resolves the top group and computes carry-out and overflow.
    // It also applies the optional clamp and feeds the output register.
    // -------------------------------------------------------------------------
    localparam int LO_L = (STAGES - 1) * W;

    logic            v_l;
    logic            c_l;
    logic [N-1:0]    x_l;
    logic [N-1:LO_L] y_l;

    if (STAGES == 1) begin : g_last_src
        assign v_l = bus.in_valid;
        assign c_l = c_eff;
        assign x_l = bus.A;
        assign y_l = b_eff;
    end else begin : g_last_src
        assign v_l = g_stage[STAGES-2].v_q;
        assign c_l = g_stage[STAGES-2].c_q;
        assign x_l = g_stage[STAGES-2].x_q;
        assign y_l = g_stage[STAGES-2].y_q;
    end

    logic [W:0]   grp_l;
    logic [N-1:0] s_raw;
    logic         of_raw;
    logic [N-1:0] s_d;

    assign grp_l = skip_group(x_l[N-1:LO_L], y_l[N-1:LO_L], c_l);

    always_comb begin
        s_raw            = x_l;
        s_raw[N-1:LO_L]  = grp_l[W-1:0];
    end

    // x_l[N-1] is still operand A's MSB, because the top group has not been
    // overwritten yet.
    assign of_raw = (x_l[N-1] == y_l[N-1]) && (s_raw[N-1] != x_l[N-1]);

`ifdef CSA_SAT_EN
    // An overflow always has the sign opposite to A, so A's MSB selects the
    // rail: positive overflow clamps to max, negative overflow to min.
    always_comb begin
        s_d = s_raw;
        if (of_raw) begin
            s_d = x_l[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end
`else
    assign s_d = s_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            of_q        <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v_l;
            if (v_l) begin
                s_q    <= s_d;
                cout_q <= grp_l[W];
                of_q   <= of_raw;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.cout      = cout_q;
    assign bus.OF        = of_q;

endmodule
